// File: rtl/i2c_write_ctrl_pkg.sv
// Shared types and constants for the single-byte I2C write controller.
// States, quarter-phase encoding and slot counts live here.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_ADDR  = 3'd2,
      ST_AACK  = 3'd3,
      ST_DATA  = 3'd4,
      ST_DACK  = 3'd5,
      ST_STOP  = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quarter_e;

   localparam int unsigned ADDR_BITS = 8;
   localparam int unsigned DATA_BITS = 8;

   // SCL is high during the second half of every bit slot.
   function automatic logic q_high(input quarter_e q);
      return (q == Q2) || (q == Q3);
   endfunction

   function automatic logic is_ack_slot(input state_e s);
      return (s == ST_AACK) || (s == ST_DACK);
   endfunction

endpackage

// File: rtl/i2c_write_ctrl_if.sv
// Request, address-unit and line signals of the I2C write controller.
// slave: the controller itself; master: the requester / address unit side.
interface i2c_write_ctrl_if;

   logic       start;
   logic [6:0] addr;
   logic [7:0] data;
   logic [6:0] au_addr;
   logic       au_go;
   logic       au_abit;
   logic       au_sda;
   logic       sda_i;
   logic       scl_o;
   logic       sda_o;
   logic       busy;
   logic       done;
   logic       ack_err;

   modport master (
      output start, addr, data, au_sda, sda_i,
      input  au_addr, au_go, au_abit, scl_o, sda_o, busy, done, ack_err
   );

   modport slave (
      input  start, addr, data, au_sda, sda_i,
      output au_addr, au_go, au_abit, scl_o, sda_o, busy, done, ack_err
   );

endinterface

// File: rtl/i2c_write_ctrl_phase_gen.sv
// Quarter-phase generator: CLK_DIV clk cycles per quarter, four quarters per
// bit slot. Counters sit at Q0/0 while disabled.
module i2c_phase_gen
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     en,
   output quarter_e quarter,
   output logic     phase_first,
   output logic     phase_last,
   output logic     slot_end
);

   localparam int unsigned CW = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   quarter_e      quarter_q, quarter_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         quarter_q <= Q0;
      end else begin
         cnt_q     <= cnt_d;
         quarter_q <= quarter_d;
      end
   end

   always_comb begin
      cnt_d     = cnt_q;
      quarter_d = quarter_q;
      if (!en) begin
         cnt_d     = '0;
         quarter_d = Q0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d     = '0;
         quarter_d = quarter_e'(quarter_q + 2'd1);
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign quarter     = quarter_q;
   assign phase_first = (cnt_q == '0);
   assign phase_last  = (cnt_q == CNT_MAX);
   assign slot_end    = (quarter_q == Q3) && (cnt_q == CNT_MAX);

endmodule

// File: rtl/i2c_write_ctrl.sv
// Single-byte I2C master write sequencer: START, address (via address unit),
// ACK, data byte MSB first, ACK, STOP. Optional NACK handling: I2C_WRITE_CTRL_ACK_CHECK_EN.
module i2c_write_ctrl
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input logic             clk,
   input logic             rst,
   i2c_write_ctrl_if.slave bus
);

   state_e     state_q, state_d;
   logic [6:0] addr_q, addr_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       done_q, done_d;
   logic       sda_prev_q, sda_prev_d;

   logic       accept;
   logic       gen_en;
   logic       au_abit;
   logic       addr_nack;
   logic       scl;
   logic       sda;

   quarter_e   quarter;
   logic       phase_first;
   logic       phase_last;
   logic       slot_end;

   assign accept = (state_q == ST_IDLE) && bus.start;
   // The accept cycle already counts as the first cycle of the START slot.
   assign gen_en = accept || (state_q != ST_IDLE);

   i2c_phase_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_phase (
      .clk        (clk),
      .rst        (rst),
      .en         (gen_en),
      .quarter    (quarter),
      .phase_first(phase_first),
      .phase_last (phase_last),
      .slot_end   (slot_end)
   );

`ifdef I2C_WRITE_CTRL_ACK_CHECK_EN
   logic ack_err_q, ack_err_d;
   logic ack_sample;

   assign ack_sample = is_ack_slot(state_q) && (quarter == Q2) && phase_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_err_q <= 1'b0;
      end else begin
         ack_err_q <= ack_err_d;
      end
   end

   always_comb begin
      ack_err_d = ack_err_q;
      if (accept) begin
         ack_err_d = 1'b0;
      end else if (ack_sample && bus.sda_i) begin
         ack_err_d = 1'b1;
      end
   end

   // ack_err is clear on entry to AACK, so a set flag at AACK end is its own NACK.
   assign addr_nack   = ack_err_q;
   assign bus.ack_err = ack_err_q;
`else
   logic unused_ack;

   assign unused_ack  = bus.sda_i ^ phase_last;
   assign addr_nack   = 1'b0;
   assign bus.ack_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         done_q     <= 1'b0;
         sda_prev_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         done_q     <= done_d;
         sda_prev_q <= sda_prev_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
      au_abit   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d  = bus.addr;
               shift_d = bus.data;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (slot_end) begin
               state_d   = ST_ADDR;
               bit_cnt_d = 3'(ADDR_BITS - 1);
            end
         end
         ST_ADDR: begin
            au_abit = (quarter == Q0) && phase_first;
            if (slot_end) begin
               if (bit_cnt_q == 3'd0) begin
                  state_d = ST_AACK;
               end else begin
                  bit_cnt_d = bit_cnt_q - 3'd1;
               end
            end
         end
         ST_AACK: begin
            if (slot_end) begin
               if (addr_nack) begin
                  state_d = ST_STOP;
               end else begin
                  state_d   = ST_DATA;
                  bit_cnt_d = 3'(DATA_BITS - 1);
               end
            end
         end
         ST_DATA: begin
            if (slot_end) begin
               shift_d = {shift_q[6:0], 1'b0};
               if (bit_cnt_q == 3'd0) begin
                  state_d = ST_DACK;
               end else begin
                  bit_cnt_d = bit_cnt_q - 3'd1;
               end
            end
         end
         ST_DACK: begin
            if (slot_end) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (slot_end) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Line levels are decoded combinationally so reset releases them at once.
   always_comb begin
      scl = 1'b1;
      sda = 1'b1;
      case (state_q)
         ST_IDLE: begin
            scl = 1'b1;
            sda = 1'b1;
         end
         ST_START: begin
            sda = !q_high(quarter);
         end
         ST_ADDR: begin
            scl = q_high(quarter);
            // Address unit shifts on au_abit; hold the old bit for that cycle.
            sda = ((quarter == Q0) && phase_first) ? sda_prev_q : bus.au_sda;
         end
         ST_AACK, ST_DACK: begin
            scl = q_high(quarter);
         end
         ST_DATA: begin
            scl = q_high(quarter);
            sda = shift_q[7];
         end
         ST_STOP: begin
            scl = (quarter != Q0);
            sda = q_high(quarter);
         end
         default: begin
            scl = 1'b1;
            sda = 1'b1;
         end
      endcase
   end

   assign sda_prev_d  = sda;

   assign bus.au_go   = accept;
   assign bus.au_abit = au_abit;
   assign bus.au_addr = addr_d;
   assign bus.busy    = (state_q != ST_IDLE);
   assign bus.done    = done_q;
   assign bus.scl_o   = scl;
   assign bus.sda_o   = sda;

endmodule

// File: tb/tb_i2c_write_ctrl.sv
// Scoreboard bench for i2c_write_ctrl: stimulus queues expected strobe/line
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_i2c_write_ctrl;

   localparam int K_GO   = 0;
   localparam int K_ABIT = 1;
   localparam int K_RISE = 2;
   localparam int K_STOP = 3;
   localparam int K_DONE = 4;

   typedef struct {
      int kind;
      int cyc;
      int val;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       start4 = 1'b0;
   logic       start1 = 1'b0;
   logic [6:0] addr_v = '0;
   logic [7:0] data_v = '0;
   logic       sda_i_v = 1'b0;
   logic       au_sda_r = 1'b0;
   logic [7:0] au_sh = '0;
   logic       sel = 1'b0;
   logic       mon_en = 1'b0;

   i2c_write_ctrl_if bus4 ();
   i2c_write_ctrl_if bus1 ();

   i2c_write_ctrl #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
   i2c_write_ctrl #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   assign bus4.start  = start4;
   assign bus4.addr   = addr_v;
   assign bus4.data   = data_v;
   assign bus4.au_sda = au_sda_r;
   assign bus4.sda_i  = sda_i_v;
   assign bus1.start  = start1;
   assign bus1.addr   = addr_v;
   assign bus1.data   = data_v;
   assign bus1.au_sda = au_sda_r;
   assign bus1.sda_i  = sda_i_v;

   logic       m_go, m_abit, m_scl, m_sda, m_busy, m_done, m_ack_err;
   logic [6:0] m_au_addr;
   assign m_go      = sel ? bus1.au_go   : bus4.au_go;
   assign m_abit    = sel ? bus1.au_abit : bus4.au_abit;
   assign m_scl     = sel ? bus1.scl_o   : bus4.scl_o;
   assign m_sda     = sel ? bus1.sda_o   : bus4.sda_o;
   assign m_busy    = sel ? bus1.busy    : bus4.busy;
   assign m_done    = sel ? bus1.done    : bus4.done;
   assign m_ack_err = sel ? bus1.ack_err : bus4.ack_err;
   assign m_au_addr = sel ? bus1.au_addr : bus4.au_addr;

   // Address unit model: loads {addr, R/W=0} on au_go, presents next bit after au_abit.
   always @(posedge clk) begin
      if (m_go) begin
         au_sh <= {m_au_addr, 1'b0};
      end else if (m_abit) begin
         au_sda_r <= au_sh[7];
         au_sh    <= {au_sh[6:0], 1'b0};
      end
   end

   int  cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ev_t exp_q[$];
   int  checks = 0;
   int  failures = 0;
   int  t0 = 0;
   int  rise_idx = 0;
   bit  in_stop = 1'b0;
   logic scl_prev = 1'b1;
   logic sda_prev = 1'b1;

   function automatic string kname(input int k);
      case (k)
         K_GO:    return "au_go";
         K_ABIT:  return "au_abit";
         K_RISE:  return "scl_rise";
         K_STOP:  return "stop_rise";
         default: return "done";
      endcase
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   task automatic push_ev(input int kind, input int c, input int val);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic handle(input int kind, input int val);
      ev_t e;
      int  rel;
      bit  match;
      if (kind == K_GO) begin
         t0       = cyc;
         rise_idx = 0;
         in_stop  = 1'b0;
      end
      if (kind == K_RISE) rise_idx++;
      rel = cyc - t0;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_%s: at cycle %0d val=%0d, required no event", kname(kind), rel, val);
      end else begin
         e = exp_q.pop_front();
         match = (e.kind == kind) || (kind == K_RISE && e.kind == K_STOP);
         if (e.kind == K_STOP) in_stop = 1'b1;
         if (!match || rel != e.cyc || val != e.val) begin
            failures++;
            $display("FAIL %s: got %s at cycle %0d val=%0d, required %s at cycle %0d val=%0d",
                     kname(e.kind), kname(kind), rel, val, kname(e.kind), e.cyc, e.val);
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (m_go)                 handle(K_GO, 0);
         if (m_abit)               handle(K_ABIT, 0);
         if (m_scl && !scl_prev)   handle(K_RISE, int'(m_sda));
         if (m_done)               handle(K_DONE, int'(m_ack_err));
         if (m_scl && scl_prev && (m_sda != sda_prev)) begin
            checks++;
            if (!((!m_sda && rise_idx == 0 && m_busy) || (m_sda && in_stop))) begin
               failures++;
               $display("FAIL sda_while_scl_high: sda %0d->%0d at cycle %0d, required stable",
                        sda_prev, m_sda, cyc - t0);
            end
         end
      end
      scl_prev = m_scl;
      sda_prev = m_sda;
   end

   task automatic set_start(input int d, input logic v);
      if (d == 1) start1 = v;
      else        start4 = v;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: %0d events outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic run_xfer(input int d, input logic [6:0] a, input logic [7:0] dat,
                           input logic [7:0] abits, input logic nack_in,
                           input logic skip, input logic aerr, input logic poke);
      int stop_s;
      push_ev(K_GO, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         push_ev(K_ABIT, 4 * d * i, 0);
         push_ev(K_RISE, 4 * d * i + 2 * d, int'(abits[8 - i]));
      end
      push_ev(K_RISE, 4 * d * 9 + 2 * d, 1);
      if (skip) begin
         stop_s = 10;
      end else begin
         for (int i = 0; i < 8; i++) push_ev(K_RISE, 4 * d * (10 + i) + 2 * d, int'(dat[7 - i]));
         push_ev(K_RISE, 4 * d * 18 + 2 * d, 1);
         stop_s = 19;
      end
      push_ev(K_STOP, 4 * d * stop_s + d, 0);
      push_ev(K_DONE, 4 * d * (stop_s + 1), int'(aerr));

      @(posedge clk);
      #1 addr_v = a; data_v = dat; sda_i_v = nack_in; set_start(d, 1'b1);
      @(posedge clk);
      #1 set_start(d, 1'b0);
      if (poke) begin
         repeat (99) @(posedge clk);
         #1 set_start(d, 1'b1); addr_v = 7'h7F; data_v = 8'h00;
         @(posedge clk);
         #1 set_start(d, 1'b0);
      end
      wait_drain(100 * d + 50);
      repeat (8) @(posedge clk);
      #1;
      chk("idle_busy", int'(m_busy), 0);
      chk("idle_scl", int'(m_scl), 1);
      chk("idle_sda", int'(m_sda), 1);
      chk("sticky_ack_err", int'(m_ack_err), int'(aerr));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic skip_exp;
`ifdef I2C_WRITE_CTRL_ACK_CHECK_EN
      skip_exp = 1'b1;
`else
      skip_exp = 1'b0;
`endif
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_scl", int'(m_scl), 1);
      chk("rst_sda", int'(m_sda), 1);
      chk("rst_busy", int'(m_busy), 0);
      chk("rst_done", int'(m_done), 0);
      chk("rst_ack_err", int'(m_ack_err), 0);
      chk("rst_au_go", int'(m_go), 0);
      chk("rst_au_abit", int'(m_abit), 0);
      chk("rst_scl_div1", int'(bus1.scl_o), 1);
      rst = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);

      // 7'h50 -> address slots carry {0x50, W} = 8'hA0
      sel = 1'b0;
      run_xfer(4, 7'h50, 8'hA5, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_xfer(4, 7'h50, 8'hA5, 8'hA0, 1'b1, skip_exp, skip_exp, 1'b0);
      run_xfer(4, 7'h50, 8'hA5, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Abort mid-transfer with reset; no events expected, lines release at once.
      mon_en = 1'b0;
      @(posedge clk);
      #1 addr_v = 7'h2B; data_v = 8'h5A; sda_i_v = 1'b0; start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      repeat (149) @(posedge clk);
      #1 chk("pre_abort_busy", int'(m_busy), 1);
      chk("pre_abort_scl", int'(m_scl), 0);
      rst = 1'b0;
      #1;
      chk("abort_scl", int'(m_scl), 1);
      chk("abort_sda", int'(m_sda), 1);
      chk("abort_busy", int'(m_busy), 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      mon_en = 1'b1;
      // 7'h2B -> {0x2B, W} = 8'h56
      run_xfer(4, 7'h2B, 8'h3C, 8'h56, 1'b0, 1'b0, 1'b0, 1'b0);

      sel = 1'b1;
      repeat (2) @(posedge clk);
      run_xfer(1, 7'h50, 8'hFF, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_xfer(1, 7'h11, 8'h81, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
